// File: rtl/shift_engine_pkg.sv
// Shared types and helpers for the shift_engine serializer/deserializer.
//   state_t   : engine FSM states
//   cnt_width : bit-counter width derived from the word length
package shift_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that must reach data_width-1. Never below one bit.
    function automatic int cnt_width(input int data_width);
        return (data_width <= 2) ? 1 : $clog2(data_width);
    endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Parallel-side handshake bundle of shift_engine.
//   start_valid/start_ready/din/lsb_first : word to transmit (master -> engine)
//   dout/dout_valid/dout_ready           : received word (engine -> master)
// master: bus-side logic; slave: the engine.
interface shift_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_valid;
    logic                  start_ready;
    logic [DATA_WIDTH-1:0] din;
    logic                  lsb_first;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output start_valid, din, lsb_first, dout_ready,
        input  start_ready, dout, dout_valid
    );

    modport slave (
        input  start_valid, din, lsb_first, dout_ready,
        output start_ready, dout, dout_valid
    );
endinterface

// File: rtl/shift_engine_bit_counter.sv
// Bit counter for shift_engine: counts strobes within one word.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous clear, wins over i_en
//   i_en       : advance by one; wraps to zero after the terminal count
//   o_tc       : counter sits at DATA_WIDTH-1 (the last bit of the word)
module bit_counter
    import shift_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);
    localparam int                     CNT_WIDTH = cnt_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0]   LAST_CNT  = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            // Wrap straight to zero on the last bit so the count never
            // leaves 0..DATA_WIDTH-1.
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LAST_CNT);

endmodule

// File: rtl/shift_engine.sv
// Full-duplex serializer/deserializer.
// Accepts a word over bus (start_*), shifts it out one bit per shift_en
// strobe, MSB- or LSB-first, while capturing serial_in, then offers the
// captured word over bus (dout_*).
//   clk, rst_n  : clock, asynchronous active-low reset
//   cl          : synchronous clear, aborts any transfer
//   shift_en    : one-cycle bit strobe
//   serial_in   : receive bit, sampled on shift_en
//   serial_out  : current transmit bit (0 outside SHIFT)
//   busy        : transfer in progress
//   bus         : parallel handshakes (slave side)
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cl,
    input  logic           shift_en,
    input  logic           serial_in,
    output logic           serial_out,
    output logic           busy,
    shift_engine_if.slave  bus
);
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_order;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_busy;
    logic                  r_start_ready;

    logic                  w_accept;
    logic                  w_strobe;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_accept = (r_state == IDLE) && r_start_ready && bus.start_valid;
    assign w_strobe = (r_state == SHIFT) && shift_en;

    // Transmit bit leaves one end while the received bit enters the other.
    assign w_shift_next = r_order ? {serial_in, r_shreg[DATA_WIDTH-1:1]}
                                  : {r_shreg[DATA_WIDTH-2:0], serial_in};

    bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (cl | w_accept),
        .i_en    (w_strobe),
        .o_tc    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_order       <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
        end else if (cl) begin
            // Clear mirrors reset one edge later; a partial word is dropped.
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_order       <= 1'b0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg       <= bus.din;
                        r_order       <= bus.lsb_first;
                        r_busy        <= 1'b1;
                        r_start_ready <= 1'b0;
                        r_state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        r_shreg <= w_shift_next;
                        if (w_last) begin
                            r_dout       <= w_shift_next;
                            r_dout_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start_ready rises only after this edge, so a new word
                    // is never taken in the same cycle dout is consumed.
                    if (bus.dout_ready) begin
                        r_dout_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign serial_out      = (r_state == SHIFT) ? (r_order ? r_shreg[0] : r_shreg[DATA_WIDTH-1])
                                                : 1'b0;
    assign busy            = r_busy;
    assign bus.start_ready = r_start_ready;
    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine (DATA_WIDTH = 8): a vector table of full
// transfers plus hand-written backpressure, idle-strobe and abort sequences.
module tb_shift_engine;
    localparam int DW = 8;

    // mode: 0 = serial_in held 0, 1 = serial_in held 1, 2 = loopback
    typedef struct {
        logic [7:0] din;
        logic       lsb;
        logic [1:0] mode;
        logic [7:0] exp_bits;   // first transmitted bit in bit 7
        logic [7:0] exp_dout;
    } vec_t;

    logic clk;
    logic rst_n;
    logic cl;
    logic shift_en;
    logic serial_out;
    logic busy;
    logic r_loop;
    logic r_si;
    wire  w_serial_in = r_loop ? serial_out : r_si;

    int n_checks;
    int n_pass;

    vec_t vecs [7];

    shift_engine_if #(.DATA_WIDTH(DW)) bus ();

    shift_engine #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cl         (cl),
        .shift_en   (shift_en),
        .serial_in  (w_serial_in),
        .serial_out (serial_out),
        .busy       (busy),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (bus.start_ready !== 1'b1 && i < 20) begin
            step();
            i++;
        end
        check("start_ready_wait", bus.start_ready, 1);
    endtask

    // Accept a word, then issue n strobes every third cycle while scrambling
    // din/lsb_first. Captures transmitted bits and checks dout_valid timing.
    task automatic start_and_shift(input logic [7:0] din, input logic lsb, input logic [1:0] mode,
                                   input int n, output logic [7:0] bits, output logic timing_ok);
        r_loop = (mode == 2'd2);
        r_si   = mode[0];
        wait_ready();
        bus.din         = din;
        bus.lsb_first   = lsb;
        bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        timing_ok = (busy === 1'b1);
        bits = '0;
        for (int k = 0; k < n; k++) begin
            repeat (2) begin
                bus.din       = 8'($urandom);
                bus.lsb_first = ~bus.lsb_first;
                step();
                if (bus.dout_valid !== 1'b0) timing_ok = 1'b0;
            end
            bits[7-k] = serial_out;
            shift_en = 1'b1;
            step();
            shift_en = 1'b0;
            if (k == DW - 1) begin
                if (bus.dout_valid !== 1'b1) timing_ok = 1'b0;
            end else begin
                if (bus.dout_valid !== 1'b0) timing_ok = 1'b0;
            end
        end
    endtask

    task automatic release_dout();
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] bits;
        logic       tok;
        logic       f_valid, f_dout, f_sr, f_busy, f_so, f_shreg;

        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; cl = 1'b0; shift_en = 1'b0; r_loop = 1'b0; r_si = 1'b0;
        bus.start_valid = 1'b0; bus.din = '0; bus.lsb_first = 1'b0; bus.dout_ready = 1'b0;

        vecs[0] = '{din: 8'hA5, lsb: 1'b0, mode: 2'd2, exp_bits: 8'hA5, exp_dout: 8'hA5};
        vecs[1] = '{din: 8'h01, lsb: 1'b1, mode: 2'd1, exp_bits: 8'h80, exp_dout: 8'hFF};
        vecs[2] = '{din: 8'h3C, lsb: 1'b1, mode: 2'd2, exp_bits: 8'h3C, exp_dout: 8'h3C};
        vecs[3] = '{din: 8'h96, lsb: 1'b0, mode: 2'd0, exp_bits: 8'h96, exp_dout: 8'h00};
        vecs[4] = '{din: 8'hFF, lsb: 1'b1, mode: 2'd0, exp_bits: 8'hFF, exp_dout: 8'h00};
        vecs[5] = '{din: 8'h4D, lsb: 1'b1, mode: 2'd1, exp_bits: 8'hB2, exp_dout: 8'hFF};
        vecs[6] = '{din: 8'h00, lsb: 1'b0, mode: 2'd1, exp_bits: 8'h00, exp_dout: 8'hFF};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_serial_out", serial_out, 0);
        rst_n = 1'b1;
        step();
        check("rst_start_ready", bus.start_ready, 1);

        // Strobes in IDLE are ignored
        f_so = 1'b1;
        repeat (4) begin
            shift_en = 1'b1;
            step();
            shift_en = 1'b0;
            if (serial_out !== 1'b0) f_so = 1'b0;
            step();
        end
        check("idle_serial_out_zero", f_so, 1);
        check("idle_busy", busy, 0);
        check("idle_cnt", dut.u_bit_counter.r_cnt, 0);
        check("idle_shreg", dut.r_shreg, 0);
        check("idle_dout", bus.dout, 0);

        // Table of complete transfers
        foreach (vecs[i]) begin
            start_and_shift(vecs[i].din, vecs[i].lsb, vecs[i].mode, DW, bits, tok);
            check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
            check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_valid_timing", i), tok, 1);
            release_dout();
            check($sformatf("vec%0d_valid_drop", i), bus.dout_valid, 0);
        end

        // Backpressure with start_valid held and strobes in DONE
        start_and_shift(8'hC3, 1'b0, 2'd2, DW, bits, tok);
        check("bp_valid_timing", tok, 1);
        bus.din = 8'h5A; bus.lsb_first = 1'b0; bus.start_valid = 1'b1;
        f_valid = 1'b1; f_dout = 1'b1; f_sr = 1'b1; f_busy = 1'b1; f_so = 1'b1; f_shreg = 1'b1;
        for (int c = 0; c < 20; c++) begin
            shift_en = c[0];
            step();
            if (bus.dout_valid !== 1'b1) f_valid = 1'b0;
            if (bus.dout !== 8'hC3)      f_dout  = 1'b0;
            if (bus.start_ready !== 1'b0) f_sr   = 1'b0;
            if (busy !== 1'b0)           f_busy  = 1'b0;
            if (serial_out !== 1'b0)     f_so    = 1'b0;
            if (dut.r_shreg !== 8'hC3)   f_shreg = 1'b0;
        end
        shift_en = 1'b0;
        check("bp_valid_held", f_valid, 1);
        check("bp_dout_stable", f_dout, 1);
        check("bp_start_ready_low", f_sr, 1);
        check("bp_busy_low", f_busy, 1);
        check("bp_serial_out_zero", f_so, 1);
        check("bp_shreg_stable", f_shreg, 1);
        release_dout();
        check("bp_ready_after_release", bus.start_ready, 1);
        check("bp_no_same_cycle_accept", busy, 0);
        step();
        bus.start_valid = 1'b0;
        check("bp_accept_next_cycle", busy, 1);
        check("bp_start_ready_after_accept", bus.start_ready, 0);

        // Abort by clear after 4 strobes
        for (int k = 0; k < 4; k++) begin
            step();
            shift_en = 1'b1;
            step();
            shift_en = 1'b0;
        end
        cl = 1'b1;
        #1;
        check("cl_waits_for_edge", busy, 1);
        step();
        cl = 1'b0;
        check("cl_busy", busy, 0);
        check("cl_start_ready", bus.start_ready, 1);
        check("cl_dout", bus.dout, 0);
        check("cl_dout_valid", bus.dout_valid, 0);
        check("cl_serial_out", serial_out, 0);
        check("cl_cnt", dut.u_bit_counter.r_cnt, 0);
        f_valid = 1'b1;
        repeat (12) begin
            shift_en = 1'b1;
            step();
            shift_en = 1'b0;
            if (bus.dout_valid !== 1'b0 || busy !== 1'b0) f_valid = 1'b0;
        end
        check("cl_no_late_valid", f_valid, 1);

        // Abort by asynchronous reset after 4 strobes
        start_and_shift(8'h5A, 1'b1, 2'd2, DW, bits, tok);
        check("pre_rst_dout", bus.dout, 8'h5A);
        release_dout();
        start_and_shift(8'h81, 1'b0, 2'd1, 4, bits, tok);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_dout", bus.dout, 0);
        check("arst_dout_valid", bus.dout_valid, 0);
        check("arst_start_ready", bus.start_ready, 1);
        check("arst_serial_out", serial_out, 0);
        #3;
        rst_n = 1'b1;
        f_valid = 1'b1;
        repeat (10) begin
            shift_en = 1'b1;
            step();
            shift_en = 1'b0;
            if (bus.dout_valid !== 1'b0 || busy !== 1'b0) f_valid = 1'b0;
        end
        check("arst_no_late_valid", f_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
Parametrised full-duplex serializer/deserializer and the successor to the plain shift register. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per external strobe, MSB- or LSB-first, while capturing the same number of bits from the serial input. It then presents the captured word through a second valid/ready handshake. It sits between a clock-divider/strobe generator and the bus-side logic of SPI-like serial links.

Parameters:
DATA_WIDTH, 8, word length in bits; legal values >= 2.
CNT_WIDTH, $clog2(DATA_WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
cl  input  1  synchronous clear, active-high
start_valid  input  1  din holds a word to transmit
start_ready  output  1  engine can accept a word
din  input  DATA_WIDTH  word to transmit
lsb_first  input  1  bit order, sampled at accept: 1 = LSB first, 0 = MSB first
shift_en  input  1  one-cycle bit strobe
serial_in  input  1  serial receive bit, sampled on shift_en
serial_out  output  1  current transmit bit
dout  output  DATA_WIDTH  received word
dout_valid  output  1  dout holds a completed word
dout_ready  input  1  consumer accepts dout
busy  output  1  a transfer is in progress

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- Reset: state IDLE; shreg, cnt, order_q, dout = 0; dout_valid = 0; busy = 0; start_ready = 1 once rst_n deasserts.
- cl has priority over all other inputs except rst_n. It gives the same values as reset on the next edge and aborts any transfer; no dout_valid is produced.
- States (enum in package): IDLE, SHIFT, DONE.
- IDLE:
  - start_ready = 1, busy = 0.
  - On start_valid && start_ready: shreg <= din, order_q <= lsb_first, cnt <= 0, go to SHIFT.
  - shift_en is ignored.
- SHIFT:
  - start_ready = 0, busy = 1.
  - serial_out = order_q ? shreg[0] : shreg[DATA_WIDTH-1]. It is combinational from registers only, so the first bit is valid the cycle after accept.
  - On shift_en with order_q = 0: shreg <= {shreg[DATA_WIDTH-2:0], serial_in}.
  - On shift_en with order_q = 1: shreg <= {serial_in, shreg[DATA_WIDTH-1:1]}.
  - On shift_en, cnt <= cnt + 1.
  - On shift_en with cnt == DATA_WIDTH-1: dout <= the shifted value, dout_valid <= 1, cnt <= 0, go to DONE.
  - Cycles without shift_en hold all state.
- DONE:
  - start_ready = 0, busy = 0, dout_valid = 1, dout stable.
  - On dout_ready: dout_valid <= 0, go to IDLE. A new word can be accepted on the following cycle; there is no same-cycle accept.
  - shift_en is ignored.
- serial_out = 0 in IDLE and DONE.
- Latency: accept edge, then DATA_WIDTH shift_en strobes, then dout_valid on the edge of the last strobe.
- Backpressure: dout_valid holds indefinitely until dout_ready.
- Received bit order: with order_q = 0, the first bit received lands in dout[DATA_WIDTH-1]; with order_q = 1, it lands in dout[0].
- lsb_first and din changing mid-transfer have no effect.
- rst_n asserted mid-transfer takes effect immediately and asynchronously; no partial word is ever presented.
- cnt never exceeds DATA_WIDTH-1; there is no wrap beyond the word.

Decomposition:
- shift_engine_pkg holds the state_t enum {IDLE, SHIFT, DONE} and a localparam helper for CNT_WIDTH.
- One sub-module is natural: bit_counter, an up-counter with async active-low reset, sync clear, enable and a terminal-count flag at DATA_WIDTH-1.
- Shift datapath and FSM stay in shift_engine.

Test Plan:
- MSB-first loopback:
  - Stimulus: DATA_WIDTH=8, din=0xA5, lsb_first=0, serial_in tied to serial_out, shift_en every 3rd cycle.
  - Required: serial_out sequence 1,0,1,0,0,1,0,1; dout=0xA5; dout_valid rises on the 8th strobe edge.
- LSB-first with constant input:
  - Stimulus: din=0x01, lsb_first=1, serial_in=1.
  - Required: serial_out 1,0,0,0,0,0,0,0; dout=0xFF.
- Backpressure:
  - Stimulus: hold dout_ready=0 for 20 cycles after completion, with start_valid=1 throughout.
  - Required: dout_valid and dout stable; start_ready=0 and busy=0 throughout. After dout_ready pulses, start_ready=1 on the next cycle and the next word is accepted one cycle later.
- Idle strobes:
  - Stimulus: shift_en pulses in IDLE and DONE.
  - Required: shreg, cnt and dout unchanged; serial_out=0.
- Abort by reset:
  - Stimulus: rst_n low after 4 of 8 strobes.
  - Required: outputs go to reset values immediately, without waiting for a clock edge, and no dout_valid appears.
- Abort by clear:
  - Stimulus: cl=1 after 4 of 8 strobes.
  - Required: the same reset values on the next edge, and no dout_valid appears.
- Mid-transfer input changes:
  - Stimulus: toggle lsb_first and din while in SHIFT.
  - Required: transmitted bits and dout match the values sampled at accept.
